// File: rtl/tcdm_rr_mux.sv
// rtl/tcdm_rr_mux.sv - round-robin N:1 TCDM multiplexer with one outstanding transaction
//
// Purpose: merges NR_INPUTS TCDM initiator ports onto a single TCDM target
// port. Arbitration is round-robin. At most one transaction is outstanding.
// Each response is routed back only to the initiator that issued the request.
// Request and response paths are purely combinational, so the mux adds no
// latency of its own.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   test_en_i            DFT enable (no functional effect)
//   mst_*_i / mst_*_o    initiator side, one entry per input port:
//                        req, add, wen (1 = read), wdata, be in;
//                        gnt, r_valid, r_rdata, r_opc out
//   slv_*_o / slv_*_i    target side: req, add, wen, wdata, be out;
//                        gnt, r_valid, r_rdata, r_opc in
module tcdm_rr_mux #(
  parameter int unsigned NR_INPUTS = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        test_en_i,
  // initiator side
  input  logic [NR_INPUTS-1:0]        mst_req_i,
  input  logic [NR_INPUTS-1:0][31:0]  mst_add_i,
  input  logic [NR_INPUTS-1:0]        mst_wen_i,
  input  logic [NR_INPUTS-1:0][31:0]  mst_wdata_i,
  input  logic [NR_INPUTS-1:0][3:0]   mst_be_i,
  output logic [NR_INPUTS-1:0]        mst_gnt_o,
  output logic [NR_INPUTS-1:0]        mst_r_valid_o,
  output logic [NR_INPUTS-1:0][31:0]  mst_r_rdata_o,
  output logic [NR_INPUTS-1:0]        mst_r_opc_o,
  // target side
  output logic                        slv_req_o,
  output logic [31:0]                 slv_add_o,
  output logic                        slv_wen_o,
  output logic [31:0]                 slv_wdata_o,
  output logic [3:0]                  slv_be_o,
  input  logic                        slv_gnt_i,
  input  logic                        slv_r_valid_i,
  input  logic [31:0]                 slv_r_rdata_i,
  input  logic                        slv_r_opc_i
);

  localparam int unsigned SEL_WIDTH = (NR_INPUTS > 1) ? $clog2(NR_INPUTS) : 1;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_e;

  state_e               state_q;
  logic [SEL_WIDTH-1:0] active_q;
  logic [SEL_WIDTH-1:0] rr_q;

  logic [SEL_WIDTH-1:0] winner;
  logic [SEL_WIDTH-1:0] rr_d;
  logic                 any_req;
  logic                 window_open;
  logic                 issue;
  logic                 handshake;

  logic unused_test_en;
  assign unused_test_en = test_en_i;

  // Rotating-priority scan starting at rr_q. Recomputed every cycle, so the
  // winner may change while the target holds gnt low.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    for (int i = 0; i < int'(NR_INPUTS); i++) begin
      int idx;
      idx = (int'(rr_q) + i) % int'(NR_INPUTS);
      if (!any_req && mst_req_i[idx]) begin
        any_req = 1'b1;
        winner  = SEL_WIDTH'(idx);
      end
    end
  end

  // A new request may go out when nothing is outstanding, or in the very cycle
  // the outstanding response returns (back-to-back issue). rst_ni gates the
  // request so nothing leaks out while reset is asserted.
  assign window_open = (state_q == IDLE) || slv_r_valid_i;
  assign issue       = rst_ni && window_open && any_req;
  assign handshake   = issue && slv_gnt_i;

  // Explicit wrap: NR_INPUTS need not be a power of two.
  assign rr_d = (winner == SEL_WIDTH'(NR_INPUTS - 1)) ? '0 : winner + SEL_WIDTH'(1);

  // Request path to the target.
  always_comb begin
    slv_req_o   = 1'b0;
    slv_add_o   = '0;
    slv_wen_o   = 1'b1;
    slv_wdata_o = '0;
    slv_be_o    = '0;
    mst_gnt_o   = '0;
    if (issue) begin
      slv_req_o         = 1'b1;
      slv_add_o         = mst_add_i[winner];
      slv_wen_o         = mst_wen_i[winner];
      slv_wdata_o       = mst_wdata_i[winner];
      slv_be_o          = mst_be_i[winner];
      mst_gnt_o[winner] = slv_gnt_i;
    end
  end

  // Response path: only the owner of the outstanding transaction sees it.
  // Responses arriving while IDLE are dropped.
  always_comb begin
    mst_r_valid_o = '0;
    mst_r_rdata_o = '0;
    mst_r_opc_o   = '0;
    if (state_q == PENDING) begin
      mst_r_valid_o[active_q] = slv_r_valid_i;
      mst_r_rdata_o[active_q] = slv_r_rdata_i;
      mst_r_opc_o[active_q]   = slv_r_opc_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      active_q <= '0;
      rr_q     <= '0;
    end else begin
      if (handshake) begin
        state_q  <= PENDING;
        active_q <= winner;
        rr_q     <= rr_d;
      end else if ((state_q == PENDING) && slv_r_valid_i) begin
        state_q  <= IDLE;
      end
    end
  end

endmodule
